// File: rtl/moore_seq_gen.sv
// moore_seq_gen: Moore-type serial pattern generator.
// Sends rep_cnt back-to-back copies of PATTERN (MSB first) on data/valid,
// then pulses done for one cycle. abort drops straight to IDLE with no done.
// Optional build macro MOORE_SEQ_GEN_GAP_EN inserts a one-cycle GAP state
// (data=0, valid=0, busy=1) between consecutive copies, never after the last.
// All outputs are registered and change only on the rising edge of clk.

module moore_seq_gen #(
  parameter int unsigned         PAT_W   = 4,
  parameter logic [PAT_W-1:0]    PATTERN = 4'b1001,
  parameter int unsigned         CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] rep_cnt,
  output logic             data,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      IDX_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef MOORE_SEQ_GEN_GAP_EN
  typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;
`endif

  state_e           r_state;
  logic [IDX_W-1:0] r_bit_idx;
  logic [CNT_W-1:0] r_rep_left;
  logic             r_data;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  logic [IDX_W-1:0] w_idx_dec;

  assign w_idx_dec = r_bit_idx - IDX_ONE;

  assign data  = r_data;
  assign valid = r_valid;
  assign busy  = r_busy;
  assign done  = r_done;

  // State, counters and registered outputs; outputs are loaded with the values
  // belonging to the state being entered, so they always match r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_bit_idx  <= IDX_LAST;
      r_rep_left <= '0;
      r_data     <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // Defaults correspond to entering IDLE.
      r_data  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // abort wins over a simultaneous start.
          if (start && !abort) begin
            r_busy <= 1'b1;
            if (rep_cnt != '0) begin
              r_state    <= StSend;
              r_rep_left <= rep_cnt;
              r_bit_idx  <= IDX_LAST;
              r_data     <= PATTERN[IDX_LAST];
              r_valid    <= 1'b1;
            end else begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end
          end
        end

        StSend: begin
          if (abort) begin
            r_state   <= StIdle;
            r_bit_idx <= IDX_LAST;
          end else if (r_bit_idx == '0) begin
            r_busy <= 1'b1;
            if (r_rep_left > CNT_ONE) begin
              r_rep_left <= r_rep_left - CNT_ONE;
              r_bit_idx  <= IDX_LAST;
`ifdef MOORE_SEQ_GEN_GAP_EN
              r_state    <= StGap;
`else
              r_state    <= StSend;
              r_data     <= PATTERN[IDX_LAST];
              r_valid    <= 1'b1;
`endif
            end else begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end
          end else begin
            r_busy    <= 1'b1;
            r_bit_idx <= w_idx_dec;
            r_data    <= PATTERN[w_idx_dec];
            r_valid   <= 1'b1;
          end
        end

`ifdef MOORE_SEQ_GEN_GAP_EN
        StGap: begin
          if (abort) begin
            r_state   <= StIdle;
            r_bit_idx <= IDX_LAST;
          end else begin
            // bit_idx was already reloaded on the way into GAP.
            r_state <= StSend;
            r_busy  <= 1'b1;
            r_data  <= PATTERN[r_bit_idx];
            r_valid <= 1'b1;
          end
        end
`endif

        StDone: begin
          r_state    <= StIdle;
          r_bit_idx  <= IDX_LAST;
          r_rep_left <= '0;
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_moore_seq_gen.sv
// Directed testbench for moore_seq_gen with default parameters
// (PAT_W=4, PATTERN=4'b1001, CNT_W=4). Follows MOORE_SEQ_GEN_GAP_EN if defined.

module tb_moore_seq_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] rep_cnt;
  logic       data;
  logic       valid;
  logic       busy;
  logic       done;

  int n_checks;
  int n_errors;

  // Per-transfer statistics gathered by run_xfer.
  logic [63:0] bits;
  logic [3:0]  win;
  int          n_valid;
  int          n_hits;
  int          n_busy;
  int          n_gap;
  int          n_done;
  int          n_viol;

`ifdef MOORE_SEQ_GEN_GAP_EN
  localparam int GapEn = 1;
`else
  localparam int GapEn = 0;
`endif

  moore_seq_gen dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .rep_cnt (rep_cnt),
    .data    (data),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a transfer and follow it until busy drops. At cycle poke_at a second
  // start with poke_rep is driven for one cycle (0 disables).
  task automatic run_xfer(input logic [3:0] rep, input int poke_at, input logic [3:0] poke_rep);
    int cyc;
    bits = '0; win = '0;
    n_valid = 0; n_hits = 0; n_busy = 0; n_gap = 0; n_done = 0; n_viol = 0;
    start = 1'b1; rep_cnt = rep;
    tick();
    start = 1'b0;
    cyc = 1;
    while (busy && cyc < 300) begin
      if (valid) begin
        bits = {bits[62:0], data};
        win  = {win[2:0], data};
        n_valid++;
        if (n_valid >= 4 && win == 4'b1001) n_hits++;
      end else if (data) begin
        n_viol++;
      end
      if (done) n_done++;
      else      n_busy++;
      if (!valid && !done) n_gap++;
      if (cyc == poke_at) begin
        start = 1'b1; rep_cnt = poke_rep;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check_eq("xfer_terminates", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [3:0] pat;
    int         late_done;
    n_checks = 0;
    n_errors = 0;
    pat      = 4'b1001;
    start    = 1'b0;
    abort    = 1'b0;
    rep_cnt  = '0;

    // Reset overrides simultaneous start and abort.
    rst = 1'b1; start = 1'b1; abort = 1'b1; rep_cnt = 4'd3;
    tick(); tick();
    check_eq("rst_data",  {31'd0, data},  32'd0);
    check_eq("rst_valid", {31'd0, valid}, 32'd0);
    check_eq("rst_busy",  {31'd0, busy},  32'd0);
    check_eq("rst_done",  {31'd0, done},  32'd0);
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    tick();
    check_eq("idle_after_rst_busy", {31'd0, busy}, 32'd0);

    // Single copy: 1,0,0,1 in cycles 1-4, done in 5, idle in 6.
    start = 1'b1; rep_cnt = 4'd1;
    tick();
    start = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      check_eq($sformatf("rep1_data_%0d", 4 - i), {31'd0, data}, {31'd0, pat[i]});
      check_eq($sformatf("rep1_valid_%0d", 4 - i), {31'd0, valid}, 32'd1);
      check_eq($sformatf("rep1_done_%0d", 4 - i), {31'd0, done}, 32'd0);
      tick();
    end
    check_eq("rep1_done_c5",  {31'd0, done},  32'd1);
    check_eq("rep1_busy_c5",  {31'd0, busy},  32'd1);
    check_eq("rep1_valid_c5", {31'd0, valid}, 32'd0);
    tick();
    check_eq("rep1_busy_c6", {31'd0, busy}, 32'd0);
    check_eq("rep1_done_c6", {31'd0, done}, 32'd0);

    // Three copies: 100110011001, three pattern hits, one done.
    run_xfer(4'd3, 0, 4'd0);
    check_eq("rep3_nvalid", n_valid,     32'd12);
    check_eq("rep3_bits",   bits[31:0],  32'h999);
    check_eq("rep3_hits",   n_hits,      32'd3);
    check_eq("rep3_ndone",  n_done,      32'd1);
    check_eq("rep3_gaps",   n_gap,       32'(2 * GapEn));
    check_eq("rep3_busy",   n_busy,      32'(12 + 2 * GapEn));
    check_eq("rep3_dzero",  n_viol,      32'd0);

    // Two copies: the gap build shows one idle bit between copies.
    run_xfer(4'd2, 0, 4'd0);
    check_eq("rep2_bits",  bits[31:0], 32'h99);
    check_eq("rep2_busy",  n_busy,     32'(8 + GapEn));
    check_eq("rep2_ndone", n_done,     32'd1);

    // Zero copies: DONE straight after start, never valid.
    start = 1'b1; rep_cnt = 4'd0;
    tick();
    start = 1'b0;
    check_eq("rep0_done",  {31'd0, done},  32'd1);
    check_eq("rep0_valid", {31'd0, valid}, 32'd0);
    check_eq("rep0_busy",  {31'd0, busy},  32'd1);
    abort = 1'b1;  // ignored in DONE
    tick();
    abort = 1'b0;
    check_eq("rep0_idle_busy",  {31'd0, busy},  32'd0);
    check_eq("rep0_idle_valid", {31'd0, valid}, 32'd0);

    // Abort at the third bit of a two-copy transfer.
    start = 1'b1; rep_cnt = 4'd2;
    tick(); start = 1'b0;
    tick();
    tick();
    check_eq("abort_third_bit", {30'd0, valid, data}, 32'h2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_valid", {31'd0, valid}, 32'd0);
    check_eq("abort_busy",  {31'd0, busy},  32'd0);
    check_eq("abort_data",  {31'd0, data},  32'd0);
    late_done = 0;
    for (int i = 0; i < 4; i++) begin
      if (done || busy) late_done++;
      tick();
    end
    check_eq("abort_no_done", late_done, 32'd0);

    // abort together with start in IDLE keeps the block idle.
    start = 1'b1; abort = 1'b1; rep_cnt = 4'd1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_eq("abort_start_busy", {31'd0, busy}, 32'd0);

    // Second start with a new rep_cnt mid-transfer is ignored.
    run_xfer(4'd1, 2, 4'd5);
    check_eq("restart_nvalid", n_valid,    32'd4);
    check_eq("restart_bits",   bits[31:0], 32'h9);
    check_eq("restart_ndone",  n_done,     32'd1);
    tick();
    check_eq("restart_idle", {31'd0, busy}, 32'd0);

    // Reset mid-transfer discards it without a done pulse.
    start = 1'b1; rep_cnt = 4'd2;
    tick(); start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    check_eq("midrst_outs", {28'd0, data, valid, busy, done}, 32'd0);
    rst = 1'b0;
    late_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy || valid) late_done++;
    end
    check_eq("midrst_quiet", late_done, 32'd0);

    // Maximum repetition count completes without wrap-around.
    run_xfer(4'd15, 0, 4'd0);
    check_eq("max_nvalid", n_valid, 32'd60);
    check_eq("max_hits",   n_hits,  32'd15);
    check_eq("max_busy",   n_busy,  32'(60 + 14 * GapEn));
    check_eq("max_ndone",  n_done,  32'd1);
    check_eq("max_dzero",  n_viol,  32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
